// File: rtl/sd_saver.sv
// Packs a 32-bit word stream into 512-byte sectors using a ping-pong buffer.
// It hands each full sector to the SD write core and slots DRAM refresh requests in between sectors.
module sd_saver #(
  parameter logic [31:0] BIN_SIZE      = 32'h0010_0000,
  parameter logic [31:0] START_SECTOR  = 32'd0,
  parameter int unsigned REFRESH_EVERY = 6,
  parameter bit          DRAM_REFRESH  = 1'b1
) (
  input  logic        clk27mhz,
  input  logic        reset,
  input  logic [2:0]  init_state,
  input  logic [31:0] DATA,
  input  logic        WE,
  output logic        READY,
  input  logic        w_dram_busy,
  input  logic        w_dram_le,
  input  logic        w_dram_we,
  output logic        r_refreshcmd,
  output logic        wstart,
  output logic [31:0] wsector,
  input  logic        wbusy,
  input  logic        wdone,
  input  logic        inreq,
  input  logic [8:0]  inaddr,
  output logic [7:0]  inbyte,
  output logic        DONE,
  output logic [2:0]  fsm_state_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_REF_WAIT = 3'd3;
  localparam logic [2:0] S_REF_CMD  = 3'd4;
  localparam logic [2:0] S_REF_BUSY = 3'd5;

  localparam logic [31:0] NUM_SECTORS = (BIN_SIZE + 32'd511) >> 9;
  localparam logic [31:0] LAST_SECTOR = NUM_SECTORS - 32'd1;
  localparam logic [31:0] REF_LIMIT   = 32'(REFRESH_EVERY);

  // Word address is {half, word index}; half 0 = words 0..127, half 1 = 128..255.
  logic [31:0] mem_q [0:255];

  logic [6:0]  widx_q, widx_d;
  logic        fh_q, fh_d;
  logic        rh_q, rh_d;
  logic [1:0]  full_q, full_d, full_set, full_clr;
  logic        padding_q, padding_d;
  logic [31:0] bytes_q, bytes_d;
  logic [2:0]  state_q, state_d;
  logic [31:0] scount_q, scount_d;
  logic [31:0] since_q, since_d;
  logic [31:0] wsector_q, wsector_d;
  logic        done_q, done_d;
  logic        armed_q;
  logic [7:0]  inbyte_q;

  logic        run;
  logic        accept;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_addr;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;

  assign run     = (init_state == 3'd3);
  // armed_q keeps READY low for the first cycle after reset.
  assign READY   = armed_q && run && !done_q && !full_q[fh_q] && !padding_q &&
                   (bytes_q < BIN_SIZE);
  assign accept  = WE && READY;
  assign wr_en   = accept || padding_q;
  assign wr_data = padding_q ? 32'd0 : DATA;
  assign wr_addr = {fh_q, widx_q};

  assign rd_word = mem_q[{rh_q, inaddr[8:2]}];
  assign rd_byte = rd_word[{inaddr[1:0], 3'b000} +: 8];

  always_comb begin
    widx_d    = widx_q;
    fh_d      = fh_q;
    padding_d = padding_q;
    bytes_d   = bytes_q;
    full_set  = 2'b00;
    if (wr_en) begin
      widx_d = widx_q + 7'd1;
      if (widx_q == 7'd127) begin
        full_set[fh_q] = 1'b1;
        fh_d           = ~fh_q;
        padding_d      = 1'b0;
      end
    end
    // A short final sector is zero-filled so the write core always sees 512 bytes.
    if (accept) begin
      bytes_d = bytes_q + 32'd4;
      if ((bytes_q + 32'd4 == BIN_SIZE) && (widx_q != 7'd127)) padding_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    rh_d      = rh_q;
    scount_d  = scount_q;
    since_d   = since_q;
    wsector_d = wsector_q;
    done_d    = done_q;
    full_clr  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (full_q[rh_q] && run) begin
          state_d = (DRAM_REFRESH && (since_q >= REF_LIMIT)) ? S_REF_WAIT : S_START;
        end
      end
      S_START: begin
        if (wbusy) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (wdone) begin
          full_clr[rh_q] = 1'b1;
          rh_d      = ~rh_q;
          scount_d  = scount_q + 32'd1;
          since_d   = (since_q == 32'hFFFF_FFFF) ? since_q : since_q + 32'd1;
          wsector_d = START_SECTOR + scount_q + 32'd1;
          if (scount_q == LAST_SECTOR) done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_REF_WAIT: begin
        if (!w_dram_busy && !w_dram_le && !w_dram_we) state_d = S_REF_CMD;
      end
      S_REF_CMD: begin
        if (w_dram_busy) state_d = S_REF_BUSY;
      end
      S_REF_BUSY: begin
        if (!w_dram_busy) begin
          since_d = 32'd0;
          state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fill and drain always target different halves, so set and clear never collide.
  assign full_d = (full_q | full_set) & ~full_clr;

  always_ff @(posedge clk27mhz) begin
    if (wr_en && !reset) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk27mhz) begin
    if (reset) begin
      widx_q    <= 7'd0;
      fh_q      <= 1'b0;
      rh_q      <= 1'b0;
      full_q    <= 2'b00;
      padding_q <= 1'b0;
      bytes_q   <= 32'd0;
      state_q   <= S_IDLE;
      scount_q  <= 32'd0;
      since_q   <= 32'd0;
      wsector_q <= START_SECTOR;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      inbyte_q  <= 8'd0;
    end else begin
      widx_q    <= widx_d;
      fh_q      <= fh_d;
      rh_q      <= rh_d;
      full_q    <= full_d;
      padding_q <= padding_d;
      bytes_q   <= bytes_d;
      state_q   <= state_d;
      scount_q  <= scount_d;
      since_q   <= since_d;
      wsector_q <= wsector_d;
      done_q    <= done_d;
      armed_q   <= 1'b1;
      if (inreq) inbyte_q <= rd_byte;
    end
  end

  assign wstart       = (state_q == S_START);
  assign r_refreshcmd = (state_q == S_REF_CMD);
  assign wsector      = wsector_q;
  assign inbyte       = inbyte_q;
  assign DONE         = done_q;
  assign fsm_state_o  = state_q;

endmodule

// File: tb/tb_sd_saver.sv
// Directed bench for sd_saver: 386 words (1544 bytes) go to sectors 5..8 with refresh every 2 sectors.
// The last sector is partially padded; the bench also checks init gating, reset mid-write and the rerun.
module tb_sd_saver;

  logic        clk27mhz = 1'b0;
  logic        reset;
  logic [2:0]  init_state;
  logic [31:0] DATA;
  logic        WE;
  logic        READY;
  logic        w_dram_busy, w_dram_le, w_dram_we;
  logic        r_refreshcmd;
  logic        wstart;
  logic [31:0] wsector;
  logic        wbusy, wdone, inreq;
  logic [8:0]  inaddr;
  logic [7:0]  inbyte;
  logic        DONE;
  logic [2:0]  fsm_state;

  int tests = 0;
  int fails = 0;
  int wstart_rises = 0;
  logic wstart_prev = 1'b0;

  always #5 clk27mhz = ~clk27mhz;

  sd_saver #(
    .BIN_SIZE(32'd1544), .START_SECTOR(32'd5), .REFRESH_EVERY(2), .DRAM_REFRESH(1'b1)
  ) dut (
    .clk27mhz(clk27mhz), .reset(reset), .init_state(init_state), .DATA(DATA), .WE(WE),
    .READY(READY), .w_dram_busy(w_dram_busy), .w_dram_le(w_dram_le), .w_dram_we(w_dram_we),
    .r_refreshcmd(r_refreshcmd), .wstart(wstart), .wsector(wsector), .wbusy(wbusy),
    .wdone(wdone), .inreq(inreq), .inaddr(inaddr), .inbyte(inbyte), .DONE(DONE),
    .fsm_state_o(fsm_state)
  );

  always @(posedge clk27mhz) begin
    wstart_prev <= wstart;
    if (wstart && !wstart_prev) wstart_rises <= wstart_rises + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: timed out waiting for DUT", tag);
  endtask

  task automatic push_word(input logic [31:0] v);
    int n = 0;
    DATA = v;
    WE   = 1'b1;
    while (!READY && n < 3000) begin
      @(negedge clk27mhz);
      n++;
    end
    if (!READY) timeout_fail("push_ready");
    @(negedge clk27mhz);
    WE = 1'b0;
  endtask

  task automatic push_words(input int base, input int count);
    for (int i = 0; i < count; i++) push_word(32'(base + i));
  endtask

  task automatic core_start(input logic [31:0] exp_sec);
    int n = 0;
    while (!wstart && n < 3000) begin
      @(negedge clk27mhz);
      n++;
    end
    if (!wstart) timeout_fail("wstart_wait");
    chk("wsector", wsector, exp_sec);
    wbusy = 1'b1;
    @(negedge clk27mhz);
    chk("wstart_drop", {31'd0, wstart}, 32'd0);
  endtask

  task automatic core_finish(input int base, input int nwords);
    logic [31:0] expw;
    logic [31:0] shifted;
    for (int a = 0; a < 512; a++) begin
      inreq  = 1'b1;
      inaddr = 9'(a);
      @(negedge clk27mhz);
      inreq   = 1'b0;
      expw    = ((a / 4) < nwords) ? 32'(base + a / 4) : 32'd0;
      shifted = expw >> (8 * (a % 4));
      chk($sformatf("inbyte[%0d]", a), {24'd0, inbyte}, {24'd0, shifted[7:0]});
    end
    wdone = 1'b1;
    @(negedge clk27mhz);
    wdone = 1'b0;
    wbusy = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init_state = 3'd2; DATA = 32'd0; WE = 1'b0;
    w_dram_busy = 1'b0; w_dram_le = 1'b0; w_dram_we = 1'b0;
    wbusy = 1'b0; wdone = 1'b0; inreq = 1'b0; inaddr = 9'd0;
    repeat (2) @(negedge clk27mhz);

    chk("rst_ready",   {31'd0, READY}, 32'd0);
    chk("rst_wstart",  {31'd0, wstart}, 32'd0);
    chk("rst_wsector", wsector, 32'd5);
    chk("rst_inbyte",  {24'd0, inbyte}, 32'd0);
    chk("rst_refresh", {31'd0, r_refreshcmd}, 32'd0);
    chk("rst_done",    {31'd0, DONE}, 32'd0);
    reset = 1'b0;

    // init_state != 3 blocks the producer
    WE = 1'b1;
    repeat (3) begin
      @(negedge clk27mhz);
      chk("init2_ready",  {31'd0, READY}, 32'd0);
      chk("init2_wstart", {31'd0, wstart}, 32'd0);
    end
    WE = 1'b0;
    init_state = 3'd3;
    @(negedge clk27mhz);
    chk("init3_ready", {31'd0, READY}, 32'd1);

    // stray wdone while idle
    wdone = 1'b1;
    @(negedge clk27mhz);
    wdone = 1'b0;
    chk("stray_wdone_sector", wsector, 32'd5);
    chk("stray_wdone_done",   {31'd0, DONE}, 32'd0);
    chk("stray_wdone_state",  {29'd0, fsm_state}, 32'd0);

    // sector 0 held busy while the second half fills
    push_words(0, 128);
    core_start(32'd5);
    push_words(128, 128);
    DATA = 32'd256;
    WE   = 1'b1;
    repeat (5) begin
      @(negedge clk27mhz);
      chk("both_full_ready", {31'd0, READY}, 32'd0);
    end
    WE = 1'b0;
    core_finish(0, 128);
    chk("ready_after_wdone", {31'd0, READY}, 32'd1);

    core_start(32'd6);
    core_finish(128, 128);

    // refresh falls due before sector 2; DRAM stays busy for a while
    w_dram_busy = 1'b1;
    push_words(256, 128);
    push_words(384, 2);
    DATA = 32'd386;
    WE   = 1'b1;
    repeat (4) begin
      @(negedge clk27mhz);
      chk("past_bin_ready", {31'd0, READY}, 32'd0);
    end
    WE = 1'b0;
    repeat (10) begin
      @(negedge clk27mhz);
      chk("refwait_cmd",    {31'd0, r_refreshcmd}, 32'd0);
      chk("refwait_wstart", {31'd0, wstart}, 32'd0);
      chk("refwait_state",  {29'd0, fsm_state}, 32'd3);
    end
    w_dram_busy = 1'b0;
    @(negedge clk27mhz);
    chk("refcmd_rise", {31'd0, r_refreshcmd}, 32'd1);
    repeat (3) begin
      @(negedge clk27mhz);
      chk("refcmd_hold",   {31'd0, r_refreshcmd}, 32'd1);
      chk("refcmd_wstart", {31'd0, wstart}, 32'd0);
    end
    w_dram_busy = 1'b1;
    @(negedge clk27mhz);
    chk("refcmd_fall", {31'd0, r_refreshcmd}, 32'd0);
    repeat (3) begin
      @(negedge clk27mhz);
      chk("refbusy_wstart", {31'd0, wstart}, 32'd0);
    end
    w_dram_busy = 1'b0;
    @(negedge clk27mhz);
    chk("after_refresh_wstart", {31'd0, wstart}, 32'd1);

    core_start(32'd7);
    core_finish(256, 128);

    // padded final sector
    core_start(32'd8);
    chk("done_before_last", {31'd0, DONE}, 32'd0);
    core_finish(384, 2);
    chk("done_after_last",  {31'd0, DONE}, 32'd1);
    chk("ready_after_done", {31'd0, READY}, 32'd0);
    chk("wstart_count",     32'(wstart_rises), 32'd4);

    // reset clears DONE, then a rerun is interrupted mid-write
    reset = 1'b1;
    @(negedge clk27mhz);
    chk("rst2_done",    {31'd0, DONE}, 32'd0);
    chk("rst2_ready",   {31'd0, READY}, 32'd0);
    chk("rst2_wsector", wsector, 32'd5);
    reset = 1'b0;

    push_words(1000, 128);
    core_start(32'd5);
    chk("rerun_in_write", {29'd0, fsm_state}, 32'd2);
    reset = 1'b1;
    @(negedge clk27mhz);
    chk("midrst_wstart",  {31'd0, wstart}, 32'd0);
    chk("midrst_ready",   {31'd0, READY}, 32'd0);
    chk("midrst_done",    {31'd0, DONE}, 32'd0);
    chk("midrst_state",   {29'd0, fsm_state}, 32'd0);
    chk("midrst_wsector", wsector, 32'd5);
    reset = 1'b0;
    wbusy = 1'b0;
    @(negedge clk27mhz);
    chk("midrst_ready_back", {31'd0, READY}, 32'd1);

    push_words(2000, 128);
    core_start(32'd5);
    core_finish(2000, 128);
    chk("rerun_not_done", {31'd0, DONE}, 32'd0);
    chk("rerun_sector",   wsector, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
